i2s_tx_sequencer: RTL and testbench

- Sequences stereo sample transmission onto the I2S bus from the ADC/codec clock domain.
- Generates BCLK and WCLK with the same divider scheme as the existing I2S clock core.
- Adds a one-deep stereo-pair buffer with a valid/ready handshake, an I2S-format serializer with a one-bit data delay, start/stop sequencing and underrun signalling.
- Sits between the audio datapath (sample producer) and the DAC pins.

---
 rtl/i2s_tx_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_i2s_tx_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: BCLK/WCLK generation, one-deep stereo-pair buffer,
// I2S serializer (MSB one BCLK after the WCLK edge) with start/stop and underrun.
module i2s_tx_sequencer #(
  parameter int CLK_DIV     = 128,
  parameter int SAMPLE_SIZE = 24,
  parameter int SLOT_BITS   = 32
) (
  input  logic                   adc_clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [SAMPLE_SIZE-1:0] s_left,
  input  logic [SAMPLE_SIZE-1:0] s_right,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   i2s_bclk,
  output logic                   i2s_wclk,
  output logic                   i2s_sdata,
  output logic                   frame_start,
  output logic                   underrun,
  output logic                   running
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(SLOT_BITS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(SLOT_BITS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          clk_cnt_q;
  logic [BW-1:0]          b_q;
  logic                   bclk_q;
  logic                   wclk_q;
  logic                   sdata_q;
  logic                   frame_start_q;
  logic                   underrun_q;
  logic                   running_q;
  logic                   buf_full_q;
  logic [SAMPLE_SIZE-1:0] buf_l_q;
  logic [SAMPLE_SIZE-1:0] buf_r_q;
  logic [SAMPLE_SIZE-1:0] shift_l_q;
  logic [SAMPLE_SIZE-1:0] shift_r_q;

  logic [CW-1:0]          clk_cnt_d;
  logic [BW-1:0]          b_d;
  logic                   tick_s;
  logic                   fall_s;
  logic                   boundary_s;
  logic                   accept_s;
  logic                   load_s;
  logic [SAMPLE_SIZE-1:0] ch_word_s;

  // Bit b_new of the slot carries sample bit [SAMPLE_SIZE-b_new]; anything else is padding.
  function automatic logic pick_bit(input logic [SAMPLE_SIZE-1:0] w, input logic [BW-1:0] bn);
    logic bit_v;
    bit_v = 1'b0;
    for (int i = 0; i < SAMPLE_SIZE; i++) begin
      if (bn == BW'(SAMPLE_SIZE - i)) begin
        bit_v = w[i];
      end
    end
    return bit_v;
  endfunction

  assign clk_cnt_d  = clk_cnt_q + CW'(1);
  assign b_d        = b_q + BW'(1);
  assign tick_s     = (clk_cnt_q == CNT_LAST);
  assign fall_s     = tick_s & bclk_q;
  assign boundary_s = (state_q == ST_RUN) & fall_s & (b_q == B_LAST) & wclk_q;
  assign accept_s   = s_valid & ~buf_full_q;
  assign ch_word_s  = wclk_q ? shift_r_q : shift_l_q;
  // A boundary that finds the buffer empty uses the pre-accept state, so a same-cycle accept waits a frame.
  assign load_s     = enable & buf_full_q & (((state_q == ST_IDLE)) | boundary_s);

  assign s_ready     = ~buf_full_q;
  assign i2s_bclk    = bclk_q;
  assign i2s_wclk    = wclk_q;
  assign i2s_sdata   = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign running     = running_q;

  // Stereo-pair buffer: filled by the handshake, emptied only by a shifter load.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
    end else if (accept_s) begin
      buf_full_q <= 1'b1;
      buf_l_q    <= s_left;
      buf_r_q    <= s_right;
    end else if (load_s) begin
      buf_full_q <= 1'b0;
    end else begin
      buf_full_q <= buf_full_q;
    end
  end

  // Sequencer FSM with clock divider, slot counter and registered bus outputs.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      clk_cnt_q     <= '0;
      b_q           <= '0;
      bclk_q        <= 1'b0;
      wclk_q        <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      running_q     <= 1'b0;
      shift_l_q     <= '0;
      shift_r_q     <= '0;
    end else begin
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          clk_cnt_q <= '0;
          b_q       <= '0;
          bclk_q    <= 1'b0;
          wclk_q    <= 1'b0;
          sdata_q   <= 1'b0;
          if (load_s) begin
            state_q       <= ST_RUN;
            shift_l_q     <= buf_l_q;
            shift_r_q     <= buf_r_q;
            frame_start_q <= 1'b1;
            running_q     <= 1'b1;
          end else begin
            running_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (tick_s) begin
            clk_cnt_q <= '0;
            bclk_q    <= ~bclk_q;
          end else begin
            clk_cnt_q <= clk_cnt_d;
          end
          if (fall_s) begin
            if (b_q < B_LAST) begin
              b_q     <= b_d;
              sdata_q <= pick_bit(ch_word_s, b_d);
            end else if (!wclk_q) begin
              wclk_q  <= 1'b1;
              b_q     <= '0;
              sdata_q <= 1'b0;
            end else if (!enable) begin
              state_q   <= ST_IDLE;
              clk_cnt_q <= '0;
              wclk_q    <= 1'b0;
              b_q       <= '0;
              sdata_q   <= 1'b0;
              running_q <= 1'b0;
            end else begin
              // Empty buffer at the boundary sends a silent frame and flags the underrun.
              shift_l_q     <= load_s ? buf_l_q : '0;
              shift_r_q     <= load_s ? buf_r_q : '0;
              underrun_q    <= ~load_s;
              frame_start_q <= 1'b1;
              wclk_q        <= 1'b0;
              b_q           <= '0;
              sdata_q       <= 1'b0;
            end
          end else begin
            b_q <= b_q;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Scoreboard bench: stimulus queues expected stereo frames, a monitor
// deserializes the I2S bus at BCLK rising edges and compares.
`timescale 1ns/1ps
module tb_i2s_tx_sequencer;

  localparam int CLK_DIV = 2;
  localparam int SS      = 24;
  localparam int SB      = 32;
  localparam int FRAME   = 4 * CLK_DIV * SB;

  logic          adc_clk = 1'b0;
  logic          rst_n   = 1'b1;
  logic          enable  = 1'b0;
  logic          s_valid = 1'b0;
  logic [SS-1:0] s_left  = '0;
  logic [SS-1:0] s_right = '0;
  logic          s_ready, i2s_bclk, i2s_wclk, i2s_sdata, frame_start, underrun, running;

  i2s_tx_sequencer #(.CLK_DIV(CLK_DIV), .SAMPLE_SIZE(SS), .SLOT_BITS(SB)) dut (
    .adc_clk(adc_clk), .rst_n(rst_n), .enable(enable),
    .s_left(s_left), .s_right(s_right), .s_valid(s_valid), .s_ready(s_ready),
    .i2s_bclk(i2s_bclk), .i2s_wclk(i2s_wclk), .i2s_sdata(i2s_sdata),
    .frame_start(frame_start), .underrun(underrun), .running(running)
  );

  always #5 adc_clk = ~adc_clk;

  typedef struct packed {
    logic [SS-1:0] l;
    logic [SS-1:0] r;
    logic          und;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   edges = 0;
  int   underrun_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge adc_clk);
    #1;
    edges++;
  endtask

  task automatic send_pair(input logic [SS-1:0] l, input logic [SS-1:0] r);
    exp_t e;
    e.l = l; e.r = r; e.und = 1'b0;
    exp_q.push_back(e);
    s_left = l; s_right = r; s_valid = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (s_ready) begin
        step();
        s_valid = 1'b0;
        return;
      end
      step();
    end
    s_valid = 1'b0;
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_fs(input string name, input int budget);
    logic found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      step();
      if (frame_start) found = 1'b1;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  // Monitor: frame bookkeeping, BCLK regularity and deserialization.
  logic          prev_bclk = 1'b0;
  bit            collecting = 1'b0;
  int            k = 0;
  logic [SS-1:0] cap_l, cap_r;
  bit            pad_ok, wclk_ok;
  exp_t          cur;
  bit            fs_valid = 1'b0;
  int            fs_cyc = 0;
  bit            tg_valid = 1'b0;
  int            tg_cyc = 0;

  always @(negedge adc_clk) begin
    cyc++;
    if (!rst_n) begin
      collecting = 1'b0;
      fs_valid   = 1'b0;
      tg_valid   = 1'b0;
      prev_bclk  = 1'b0;
    end else begin
      if (underrun) begin
        underrun_cnt++;
        check("underrun_with_frame_start", {31'd0, frame_start}, 32'd1);
      end
      if (running && (i2s_bclk !== prev_bclk)) begin
        if (tg_valid) check("bclk_half_period", cyc - tg_cyc, CLK_DIV);
        tg_valid = 1'b1;
        tg_cyc   = cyc;
      end
      if (!running) tg_valid = 1'b0;
      if (frame_start) begin
        if (fs_valid) check("frame_spacing", cyc - fs_cyc, FRAME);
        fs_valid = 1'b1;
        fs_cyc   = cyc;
        if (collecting) check("frame_truncated", k, 2 * SB);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: frame_start with no expected frame at %0t", $time);
          collecting = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          check("underrun_flag", {31'd0, underrun}, {31'd0, cur.und});
          collecting = 1'b1;
          k = 0; cap_l = '0; cap_r = '0; pad_ok = 1'b1; wclk_ok = 1'b1;
        end
      end else if (collecting && i2s_bclk && !prev_bclk) begin
        k++;
        if (i2s_wclk !== (k > SB)) wclk_ok = 1'b0;
        if (k >= 2 && k <= SS + 1) cap_l = {cap_l[SS-2:0], i2s_sdata};
        else if (k >= SB + 2 && k <= SB + SS + 1) cap_r = {cap_r[SS-2:0], i2s_sdata};
        else if (i2s_sdata !== 1'b0) pad_ok = 1'b0;
        if (k == 2 * SB) begin
          collecting = 1'b0;
          check("left_sample", {8'd0, cap_l}, {8'd0, cur.l});
          check("right_sample", {8'd0, cap_r}, {8'd0, cur.r});
          check("slot_padding_zero", {31'd0, pad_ok}, 32'd1);
          check("wclk_slot_level", {31'd0, wclk_ok}, 32'd1);
        end
      end
      if (!running) fs_valid = 1'b0;
      prev_bclk = i2s_bclk;
    end
  end

  initial begin
    int   e0;
    logic found;
    exp_t ue;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_bclk", {31'd0, i2s_bclk}, 32'd0);
    check("rst_wclk", {31'd0, i2s_wclk}, 32'd0);
    check("rst_sdata", {31'd0, i2s_sdata}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    #9 rst_n = 1'b1;
    step();

    // Pair accepted while disabled: buffer fills, bus stays quiet
    send_pair(24'hA5C3F1, 24'h5A3C0F);
    check("s_ready_after_accept", {31'd0, s_ready}, 32'd0);
    repeat (20) step();
    check("idle_bclk", {31'd0, i2s_bclk}, 32'd0);
    check("idle_wclk", {31'd0, i2s_wclk}, 32'd0);
    check("idle_sdata", {31'd0, i2s_sdata}, 32'd0);
    check("idle_running", {31'd0, running}, 32'd0);

    // Start: entry frame, then continuous supply
    enable = 1'b1;
    step();
    check("entry_frame_start", {31'd0, frame_start}, 32'd1);
    check("entry_running", {31'd0, running}, 32'd1);
    check("entry_buffer_cleared", {31'd0, s_ready}, 32'd1);
    send_pair(24'h123456, 24'hFEDCBA);
    send_pair(24'h800001, 24'h7FFFFE);
    send_pair(24'hFFFFFF, 24'h000001);

    // Producer stops: the frame after the last pair is a silent underrun frame
    ue.l = '0; ue.r = '0; ue.und = 1'b1;
    exp_q.push_back(ue);
    found = 1'b0;
    for (int n = 0; n < 3 * FRAME && !found; n++) begin
      step();
      if (underrun) found = 1'b1;
    end
    check("underrun_seen", {31'd0, found}, 32'd1);
    send_pair(24'h0F0F0F, 24'hC3C3C3);

    // Stop mid-left-slot: frame finishes, IDLE at the boundary, buffer retained
    wait_fs("wait_frame_after_underrun", FRAME + 10);
    e0 = edges;
    send_pair(24'h654321, 24'hABCDEF);
    repeat (60) step();
    enable = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      step();
      if (!running) found = 1'b1;
    end
    check("stop_reached_idle", {31'd0, found}, 32'd1);
    check("stop_at_boundary", edges - e0, FRAME);
    check("stop_bclk", {31'd0, i2s_bclk}, 32'd0);
    check("stop_wclk", {31'd0, i2s_wclk}, 32'd0);
    check("stop_sdata", {31'd0, i2s_sdata}, 32'd0);
    check("stop_buffer_retained", {31'd0, s_ready}, 32'd0);
    repeat (20) step();
    check("stop_stays_idle", {31'd0, running}, 32'd0);

    // Restart with the retained pair, then reset mid-right-slot
    enable = 1'b1;
    wait_fs("restart_frame_start", 10);
    repeat (CLK_DIV * 2 * SB + 60) step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bclk", {31'd0, i2s_bclk}, 32'd0);
    check("async_rst_wclk", {31'd0, i2s_wclk}, 32'd0);
    check("async_rst_sdata", {31'd0, i2s_sdata}, 32'd0);
    check("async_rst_running", {31'd0, running}, 32'd0);
    check("async_rst_s_ready", {31'd0, s_ready}, 32'd1);
    step();
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check("post_rst_no_restart", {31'd0, running}, 32'd0);

    // New pair restarts the sequencer
    send_pair(24'h3C5A96, 24'h96A53C);
    wait_fs("post_rst_frame_start", 10);
    enable = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      step();
      if (!running) found = 1'b1;
    end
    check("final_idle", {31'd0, found}, 32'd1);
    repeat (4) step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("frame_complete", {31'd0, collecting}, 32'd0);
    check("underrun_count", underrun_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
